// File: rtl/mem_arbiter.sv
// Two-port arbiter sharing one byte-banked RAM between instruction fetch and load/store.
// Optional alignment fault reporting on the data port is enabled by defining ARB_ALIGN_CHECK_EN.
module mem_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int RAM_AW       = 10,
    parameter int MAX_D_STREAK = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_ack,
    output logic [31:0]       i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [3:0]        d_sel,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    output logic              d_ack,
    output logic [31:0]       d_rdata,
`ifdef ARB_ALIGN_CHECK_EN
    output logic              d_err,
`endif
    output logic              ram_ce,
    output logic              ram_we,
    output logic [3:0]        ram_sel,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata
);

    // Handshake: a port's req is sampled only in IDLE and held until its one-cycle ack.
    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;
    typedef enum logic [1:0] {OWN_NONE, OWN_I, OWN_D} owner_t;

    state_t      state, state_next;
    owner_t      owner;
    logic        grant_i, grant_d;
    logic [3:0]  streak;
    logic        err_q;
    logic        d_misaligned;
    logic [31:0] i_rdata_q, d_rdata_q;

`ifdef ARB_ALIGN_CHECK_EN
    assign d_misaligned = ((d_sel == 4'b1111) && (d_addr[1:0] != 2'b00)) ||
                          (((d_sel == 4'b0011) || (d_sel == 4'b1100)) && d_addr[0]) ||
                          (d_sel == 4'b0000);
`else
    assign d_misaligned = 1'b0;
`endif

    logic unused_addr_bits;
    assign unused_addr_bits = ^{i_addr[ADDR_W-1:RAM_AW+2], i_addr[1:0],
                                d_addr[ADDR_W-1:RAM_AW+2], d_addr[1:0]};

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        grant_i    = 1'b0;
        grant_d    = 1'b0;
        case (state)
            IDLE: begin
                if (d_req && (!i_req || (streak != 4'(MAX_D_STREAK)))) grant_d = 1'b1;
                else if (i_req)                                         grant_i = 1'b1;
                if (grant_d || grant_i) state_next = ISSUE;
            end
            ISSUE:   state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ram_ce    <= 1'b0;
            ram_we    <= 1'b0;
            ram_sel   <= 4'b0000;
            ram_addr  <= '0;
            ram_wdata <= '0;
            i_ack     <= 1'b0;
            d_ack     <= 1'b0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
            owner     <= OWN_NONE;
            streak    <= 4'd0;
            err_q     <= 1'b0;
        end else begin
            i_ack <= 1'b0;
            d_ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_d) begin
                        // A misaligned access still completes the handshake but never touches RAM.
                        ram_ce    <= !d_misaligned;
                        ram_we    <= d_we;
                        ram_sel   <= d_sel;
                        ram_addr  <= d_addr[RAM_AW+1:2];
                        ram_wdata <= d_wdata;
                        owner     <= OWN_D;
                        err_q     <= d_misaligned;
                        if (!i_req)               streak <= 4'd0;
                        else if (streak != 4'hF)  streak <= streak + 4'd1;
                    end else if (grant_i) begin
                        ram_ce   <= 1'b1;
                        ram_we   <= 1'b0;
                        ram_sel  <= 4'b0000;
                        ram_addr <= i_addr[RAM_AW+1:2];
                        owner    <= OWN_I;
                        err_q    <= 1'b0;
                        streak   <= 4'd0;
                    end
                end
                ISSUE: begin
                    ram_ce <= 1'b0;
                    ram_we <= 1'b0;
                    if (owner == OWN_I) i_ack <= 1'b1;
                    if (owner == OWN_D) d_ack <= 1'b1;
                end
                RESP: begin
                    if (owner == OWN_I)            i_rdata_q <= ram_rdata;
                    if (owner == OWN_D && !err_q)  d_rdata_q <= ram_rdata;
                    owner <= OWN_NONE;
                end
                default: owner <= OWN_NONE;
            endcase
        end
    end

`ifdef ARB_ALIGN_CHECK_EN
    assign d_err = d_ack && err_q;
`endif

    // RAM data arrives during the ack cycle; afterwards the captured copy holds it.
    assign i_rdata = i_ack ? ram_rdata : i_rdata_q;
    assign d_rdata = (d_ack && !err_q) ? ram_rdata : d_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed scoreboard bench for mem_arbiter with a byte-banked synchronous RAM model.
// Covers the ARB_ALIGN_CHECK_EN fault path when that macro is defined.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req, d_req, d_we;
    logic [31:0] i_addr, d_addr, d_wdata;
    logic [3:0]  d_sel;
    logic        i_ack, d_ack, d_err;
    logic [31:0] i_rdata, d_rdata;
    logic        ram_ce, ram_we;
    logic [3:0]  ram_sel;
    logic [9:0]  ram_addr;
    logic [31:0] ram_wdata, ram_rdata;

    logic [31:0] mem [0:1023];
    int          ce_count = 0;
    int          vectors = 0;
    int          miscompares = 0;
    // Entry: [35:34] ack port {i,d}, [33] err, [32] compare data, [31:0] data.
    logic [35:0] exp_q[$];

    always #5 clk = ~clk;

    mem_arbiter dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_sel(d_sel), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata),
`ifdef ARB_ALIGN_CHECK_EN
        .d_err(d_err),
`endif
        .ram_ce(ram_ce), .ram_we(ram_we), .ram_sel(ram_sel), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

`ifndef ARB_ALIGN_CHECK_EN
    assign d_err = 1'b0;
`endif

    always @(posedge clk) begin
        if (ram_ce) begin
            ce_count <= ce_count + 1;
            ram_rdata <= mem[ram_addr];
            for (int b = 0; b < 4; b++)
                if (ram_we && ram_sel[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
        end
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        logic [35:0] e;
        if (i_ack || d_ack) begin
            if (exp_q.size() == 0) begin
                check("unexpected_ack", {i_ack, d_ack}, 2'b00);
            end else begin
                e = exp_q.pop_front();
                check("ack_port", {i_ack, d_ack}, e[35:34]);
                check("ack_err", d_err, e[33]);
                if (e[32]) check("ack_rdata", i_ack ? i_rdata : d_rdata, e[31:0]);
            end
        end
    end

    // One isolated request: expects ack two cycles after the request is sampled.
    task automatic single(input string name, input logic is_d, input logic we,
                          input logic [3:0] sel, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [35:0] exp,
                          input logic exp_ce);
        int   n;
        logic got;
        logic ce_issue;
        logic [14:0] cmd_issue;
        exp_q.push_back(exp);
        @(posedge clk); #1;
        if (is_d) begin
            d_we = we; d_sel = sel; d_addr = addr; d_wdata = wdata; d_req = 1'b1;
        end else begin
            i_addr = addr; i_req = 1'b1;
        end
        n = 0; got = 1'b0; ce_issue = 1'b0; cmd_issue = '0;
        while (!got && n < 10) begin
            @(negedge clk);
            if (n == 1) begin
                ce_issue  = ram_ce;
                cmd_issue = {ram_we, ram_sel, ram_addr};
            end
            if (is_d ? d_ack : i_ack) got = 1'b1;
            else n++;
        end
        i_req = 1'b0; d_req = 1'b0;
        check({name, "_latency"}, n, 2);
        check({name, "_issue_ce"}, ce_issue, exp_ce);
        check({name, "_issue_cmd"}, cmd_issue,
              is_d ? {we, sel, addr[11:2]} : {5'b00000, addr[11:2]});
    endtask

    initial begin
        int d_at, i_at, dcnt, d_before, ce_before;
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int d_at, i_at, dcnt, d_before, ce_before;
        for (int k = 0; k < 1024; k++) mem[k] = 32'h0;
        mem[0] = 32'h11223344;
        mem[1] = 32'h01020304;
        mem[2] = 32'h8C010000;
        mem[4] = 32'hA5A5A5A5;
        rst = 1'b1; i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        i_addr = '0; d_addr = '0; d_wdata = '0; d_sel = '0;
        repeat (3) @(negedge clk);
        check("reset_outputs",
              {ram_ce, ram_we, ram_sel, ram_addr, ram_wdata, i_ack, d_ack, d_err, i_rdata, d_rdata}, '0);
        rst = 1'b0;

        single("fetch8", 1'b0, 1'b0, 4'h0, 32'h8, 32'h0, {2'b10, 1'b0, 1'b1, 32'h8C010000}, 1'b1);
        single("store_byte", 1'b1, 1'b1, 4'b0100, 32'h2, 32'h00FF0000, {2'b01, 1'b0, 1'b0, 32'h0}, 1'b1);
        @(negedge clk);
        check("ram_word0_after_store", mem[0], 32'h11FF3344);
        single("load0", 1'b1, 1'b0, 4'b1111, 32'h0, 32'h0, {2'b01, 1'b0, 1'b1, 32'h11FF3344}, 1'b1);
        check("i_rdata_hold", i_rdata, 32'h8C010000);
        single("store_word", 1'b1, 1'b1, 4'b1111, 32'hC, 32'hCAFEF00D, {2'b01, 1'b0, 1'b0, 32'h0}, 1'b1);
        single("loadC", 1'b1, 1'b0, 4'b1111, 32'hC, 32'h0, {2'b01, 1'b0, 1'b1, 32'hCAFEF00D}, 1'b1);
        single("store_half", 1'b1, 1'b1, 4'b0011, 32'h10, 32'h0000BEEF, {2'b01, 1'b0, 1'b0, 32'h0}, 1'b1);
        single("load10", 1'b1, 1'b0, 4'b1111, 32'h10, 32'h0, {2'b01, 1'b0, 1'b1, 32'hA5A5BEEF}, 1'b1);

        // Simultaneous requests: data first, then fetch three cycles later.
        exp_q.push_back({2'b01, 1'b0, 1'b1, 32'hCAFEF00D});
        exp_q.push_back({2'b10, 1'b0, 1'b1, 32'h8C010000});
        @(posedge clk); #1;
        d_we = 1'b0; d_sel = 4'b1111; d_addr = 32'hC; i_addr = 32'h8;
        d_req = 1'b1; i_req = 1'b1;
        d_at = -1; i_at = -1;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (d_ack) begin d_at = n; d_req = 1'b0; end
            if (i_ack) begin i_at = n; i_req = 1'b0; end
            if (d_at >= 0 && i_at >= 0) break;
        end
        d_req = 1'b0; i_req = 1'b0;
        check("conflict_d_cycle", d_at, 2);
        check("conflict_i_cycle", i_at, 5);

        // Fetch held while data keeps requesting: 4 data grants, then the fetch.
        for (int k = 0; k < 4; k++) exp_q.push_back({2'b01, 1'b0, 1'b1, 32'h11FF3344});
        exp_q.push_back({2'b10, 1'b0, 1'b1, 32'h8C010000});
        for (int k = 0; k < 2; k++) exp_q.push_back({2'b01, 1'b0, 1'b1, 32'h11FF3344});
        @(posedge clk); #1;
        d_we = 1'b0; d_sel = 4'b1111; d_addr = 32'h0; i_addr = 32'h8;
        d_req = 1'b1; i_req = 1'b1;
        dcnt = 0; i_at = -1; d_before = -1;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (i_ack) begin i_at = n; d_before = dcnt; i_req = 1'b0; end
            if (d_ack) begin
                dcnt++;
                if (dcnt == 6) begin d_req = 1'b0; break; end
            end
        end
        d_req = 1'b0; i_req = 1'b0;
        check("starve_data_before_fetch", d_before, 4);
        check("starve_fetch_cycle", i_at, 14);
        check("starve_total_data", dcnt, 6);

`ifdef ARB_ALIGN_CHECK_EN
        ce_before = ce_count;
        single("misaligned_word", 1'b1, 1'b0, 4'b1111, 32'h6, 32'h0, {2'b01, 1'b1, 1'b1, 32'h11FF3344}, 1'b0);
        single("misaligned_store", 1'b1, 1'b1, 4'b1111, 32'h5, 32'hFFFFFFFF, {2'b01, 1'b1, 1'b1, 32'h11FF3344}, 1'b0);
        @(negedge clk);
        check("misaligned_no_ram_access", ce_count - ce_before, 0);
        check("misaligned_ram_unchanged", mem[1], 32'h01020304);
        single("aligned_half", 1'b1, 1'b0, 4'b1100, 32'h2, 32'h0, {2'b01, 1'b0, 1'b1, 32'h11FF3344}, 1'b1);
`endif

        // Reset during ISSUE of a store abandons it without an ack.
        @(posedge clk); #1;
        d_we = 1'b1; d_sel = 4'b1111; d_addr = 32'h4; d_wdata = 32'hDEADBEEF; d_req = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("midreset_issue_ce", ram_ce, 1'b1);
        rst = 1'b1; d_req = 1'b0;
        @(negedge clk);
        check("midreset_outputs",
              {ram_ce, ram_we, ram_sel, ram_addr, ram_wdata, i_ack, d_ack, d_err, i_rdata, d_rdata}, '0);
        rst = 1'b0;
        @(negedge clk);
        check("midreset_no_ack", {i_ack, d_ack}, 2'b00);
        single("fetch_after_reset", 1'b0, 1'b0, 4'h0, 32'h8, 32'h0, {2'b10, 1'b0, 1'b1, 32'h8C010000}, 1'b1);

        repeat (3) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single byte-banked data RAM (bank3..bank0, one byte lane each) between the CPU instruction-fetch port and the load/store port.
- Sits in top between openmips and ram.
- Arbitrates between the two ports, registers one RAM command per transaction, and returns read data with a single-cycle ack pulse.
- Data port has priority; a streak limit prevents fetch starvation.

Parameters:
- ADDR_W, 32, byte-address width on both ports.
- RAM_AW, 10, word-address width driven to ram (ram_addr = addr[RAM_AW+1:2]).
- MAX_D_STREAK, 4, max consecutive data grants while i_req pending; range 1..15.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- i_req  in  1  fetch request; held until i_ack.
- i_addr  in  ADDR_W  fetch byte address (word aligned).
- i_ack  out  1  one-cycle pulse; i_rdata valid this cycle.
- i_rdata  out  32  fetched word.
- d_req  in  1  load/store request; held until d_ack.
- d_we  in  1  1 = store, 0 = load.
- d_sel  in  4  byte-lane enables; bit n = bankn.
- d_addr  in  ADDR_W  data byte address.
- d_wdata  in  32  store data, lanes pre-positioned.
- d_ack  out  1  one-cycle pulse; d_rdata valid for loads.
- d_rdata  out  32  load word, all four lanes.
- d_err  out  1  alignment fault pulse; exists only with ARB_ALIGN_CHECK_EN.
- ram_ce  out  1  RAM chip enable, registered.
- ram_we  out  1  RAM write enable, registered.
- ram_sel  out  4  RAM byte-lane write enables, registered.
- ram_addr  out  RAM_AW  RAM word address, registered.
- ram_wdata  out  32  RAM write data, registered.
- ram_rdata  in  32  RAM read data, valid the cycle after ram_ce.

Behaviour:
- Reset: state IDLE; ram_ce, ram_we, i_ack, d_ack, d_err = 0; ram_sel = 0; ram_addr, ram_wdata, i_rdata, d_rdata = 0; owner = none; streak = 0.
  - Reset mid-transaction abandons it; no ack is issued.
- FSM states: IDLE -> ISSUE -> RESP -> IDLE.
- IDLE:
  - Neither req: stay in IDLE.
  - Only one req: grant that port.
  - Both req: grant data unless streak == MAX_D_STREAK; in that case grant fetch.
  - On grant: register the command into the ram_* outputs, record owner, go to ISSUE.
  - Fetch grants drive ram_we = 0 and ram_sel = 4'b0000.
- ISSUE: ram_ce = 1 for exactly this cycle; RAM samples the command; go to RESP.
- RESP:
  - ram_ce = 0.
  - Pulse the owner's ack.
  - Present ram_rdata on the owner's rdata (i_rdata / d_rdata, registered, held until the next ack of that port).
  - Go to IDLE.
  - Stores also ack in RESP; d_rdata is don't-care for stores.
- Latency: req sampled in cycle T -> ack in T+2. Minimum period is 3 cycles per transaction.
- Requester rule: req must be low in the cycle after ack, or it counts as a new request. req, addr, sel, we and wdata are ignored outside IDLE.
- Streak counter (4-bit, saturating):
  - Increments on a data grant while i_req = 1.
  - Clears on any fetch grant.
  - Clears on any data grant while i_req = 0.
- Simultaneous requests at reset release: data is granted first.
- No write merging, no buffering beyond a single outstanding transaction.

Optional Feature:
- Macro: ARB_ALIGN_CHECK_EN.
- Defined:
  - In IDLE, a data request is misaligned when:
    - d_sel is 4'b1111 and d_addr[1:0] != 0, or
    - d_sel is 4'b0011 or 4'b1100 and d_addr[0] != 0, or
    - d_sel == 0.
  - A misaligned request is still granted, but ram_ce stays 0 in ISSUE.
  - In RESP, d_ack and d_err pulse together; d_rdata is unchanged; streak is updated as for a normal grant.
- Undefined: no check; d_err port absent; every granted request accesses RAM.

Test Plan:
- Fetch only: i_req = 1, i_addr = 0x0008, ram word 2 = 0x8C010000 -> ram_ce high in T+1 with ram_addr = 2; i_ack and i_rdata = 0x8C010000 in T+2.
- Byte store then word load: d_we = 1, d_sel = 4'b0100, d_addr = 0x0002, d_wdata = 0x00FF0000 on a word preset to 0x11223344 -> word becomes 0x11FF3344; following load of 0x0000 returns d_rdata = 0x11FF3344.
- Conflict: i_req and d_req asserted in the same cycle -> data acked first (T+2); fetch granted at T+3 and acked at T+5.
- Starvation: d_req reasserted every IDLE with i_req held, MAX_D_STREAK = 4 -> exactly 4 data acks, then i_ack, then data resumes.
- Reset mid-operation: rst = 1 during ISSUE of a store -> no ack; ram_ce = 0 next cycle; outputs at reset values; a clean fetch afterwards completes in 2 cycles.
- With ARB_ALIGN_CHECK_EN: word load at d_addr = 0x0006 -> d_ack and d_err pulse together at T+2; ram_ce never asserted; RAM contents unchanged.
